// File: rtl/psum_store_engine_pkg.sv
// Shared types for the psum store engine: FSM state encoding and accumulation mode codes.
package psum_store_engine_pkg;

    typedef enum logic [1:0] {
        ST_ACC,
        ST_DRAIN,
        ST_CLR
    } state_t;

    localparam logic MODE_SINGLE     = 1'b0;
    localparam logic MODE_INTERLEAVE = 1'b1;

endpackage

// File: rtl/psum_sync_fifo.sv
// Synchronous valid/ready FIFO with wrap-bit pointers; head reads as zero when empty.
module psum_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0]      wr_ptr, rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             full, empty, push, pop;

    always_comb begin
        empty     = (wr_ptr == rd_ptr);
        full      = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
        in_ready  = ~full;
        out_valid = ~empty;
        push      = in_valid & ~full;
        pop       = out_ready & ~empty;
        out_data  = empty ? '0 : mem[rd_ptr[PW-1:0]];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[PW-1:0]] <= in_data;
    end

endmodule

// File: rtl/psum_store_engine.sv
// Psum accumulator/drainer with valid/ready streams, pending drain and overflow tracking.
// Optional PSUM_SATURATE_EN: clamp overflowing sums instead of wrapping.
module psum_store_engine
    import psum_store_engine_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int PSUM_DEPTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int N_WIDTH    = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mode,
    input  logic [N_WIDTH-1:0]    n,
    input  logic                  mult_valid,
    input  logic [DATA_WIDTH-1:0] mult_data,
    input  logic                  mult_last,
    output logic                  stall,
    input  logic                  ipsum_valid,
    input  logic [DATA_WIDTH-1:0] ipsum_data,
    output logic                  ipsum_ready,
    input  logic                  acc_in_psum,
    input  logic                  drain_req,
    output logic                  busy,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic                  ovf,
    output logic [ADDR_WIDTH:0]   occupancy
);

    localparam int WPW = ADDR_WIDTH + 1;

    state_t                 state, state_nx;
    logic [WPW-1:0]         wp, rp;
    logic [N_WIDTH-1:0]     ch, n_r, eff_n;
    logic                   first, pend, wrapped, mode_r, acc_l, eff_mode;
    logic [DATA_WIDTH-1:0]  spad [PSUM_DEPTH];

    logic [31:0]            span;
    logic                   beat, last_ch, commit, do_add;
    logic [ADDR_WIDTH-1:0]  addr;
    logic [DATA_WIDTH:0]    acc_res, drn_res;
    logic [DATA_WIDTH-1:0]  wr_data, rd_ent, in_head, push_data;
    logic                   in_vld, in_pop, out_room, can_pop;

    // Bit DATA_WIDTH of the result carries the overflow indication.
    function automatic logic [DATA_WIDTH:0] psum_add(input logic [DATA_WIDTH-1:0] a,
                                                     input logic [DATA_WIDTH-1:0] b);
        logic [DATA_WIDTH:0]   s;
        logic [DATA_WIDTH-1:0] r;
        logic                  o;
        s = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
        o = (a[DATA_WIDTH-1] == b[DATA_WIDTH-1]) && (s[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
        r = s[DATA_WIDTH-1:0];
`ifdef PSUM_SATURATE_EN
        if (o) r = a[DATA_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
`endif
        return {o, r};
    endfunction

    always_comb begin
        eff_mode = first ? mode : mode_r;
        eff_n    = first ? n : n_r;
        span     = (eff_mode == MODE_INTERLEAVE) ? 32'(eff_n) : 32'd1;
        busy     = (state != ST_ACC);
        stall    = busy | ((32'(wp) + span) > 32'(PSUM_DEPTH)) | (pend & first);
        beat     = mult_valid & ~stall;
        last_ch  = (ch == eff_n - 1'b1);
        addr     = (eff_mode == MODE_INTERLEAVE) ? wp[ADDR_WIDTH-1:0] + ADDR_WIDTH'(ch)
                                                 : wp[ADDR_WIDTH-1:0];
        do_add   = (eff_mode == MODE_INTERLEAVE) ? wrapped : ~first;
        acc_res  = psum_add(spad[addr], mult_data);
        wr_data  = do_add ? acc_res[DATA_WIDTH-1:0] : mult_data;
        commit   = beat & mult_last & ((eff_mode == MODE_SINGLE) | last_ch);

        rd_ent    = spad[rp[ADDR_WIDTH-1:0]];
        drn_res   = psum_add(rd_ent, in_head);
        can_pop   = (state == ST_DRAIN) && (rp != wp) && out_room && (~acc_l || in_vld);
        push_data = acc_l ? drn_res[DATA_WIDTH-1:0] : rd_ent;
        in_pop    = can_pop & acc_l;
        occupancy = wp;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_ACC: begin
                if (drain_req && first && !pend)
                    state_nx = (wp == '0) ? ST_CLR : ST_DRAIN;
                else if (commit && (pend || drain_req))
                    state_nx = ST_DRAIN;
            end
            ST_DRAIN: if (rp == wp) state_nx = ST_CLR;
            ST_CLR:   state_nx = ST_ACC;
            default:  state_nx = ST_ACC;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_ACC;
            wp      <= '0;
            rp      <= '0;
            ch      <= '0;
            n_r     <= '0;
            first   <= 1'b1;
            pend    <= 1'b0;
            wrapped <= 1'b0;
            mode_r  <= MODE_SINGLE;
            acc_l   <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            state <= state_nx;
            ovf   <= ovf | (beat & do_add & acc_res[DATA_WIDTH]) | (in_pop & drn_res[DATA_WIDTH]);
            case (state)
                ST_ACC: begin
                    rp    <= '0;
                    acc_l <= acc_in_psum;
                    if (drain_req && !first) pend <= 1'b1;
                    if (beat) begin
                        if (first) begin
                            mode_r <= mode;
                            n_r    <= n;
                        end
                        first <= 1'b0;
                        if (eff_mode == MODE_INTERLEAVE) begin
                            ch <= last_ch ? '0 : ch + 1'b1;
                            if (last_ch) wrapped <= 1'b1;
                        end
                        if (commit) begin
                            wp      <= wp + WPW'(span);
                            first   <= 1'b1;
                            ch      <= '0;
                            wrapped <= 1'b0;
                        end
                    end
                end
                ST_DRAIN: if (can_pop) rp <= rp + 1'b1;
                ST_CLR: begin
                    wp      <= '0;
                    ch      <= '0;
                    pend    <= 1'b0;
                    first   <= 1'b1;
                    wrapped <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (beat) spad[addr] <= wr_data;
    end

    psum_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_in_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (ipsum_valid),
        .in_data   (ipsum_data),
        .in_ready  (ipsum_ready),
        .out_valid (in_vld),
        .out_data  (in_head),
        .out_ready (in_pop)
    );

    psum_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_out_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (can_pop),
        .in_data   (push_data),
        .in_ready  (out_room),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

endmodule

// File: tb/tb_psum_store_engine.sv
// Directed self-checking bench for psum_store_engine (PSUM_DEPTH=4 instance).
module tb_psum_store_engine;

    localparam int DW = 16;
    localparam int AW = 2;
    localparam int NW = 4;

    logic          clk = 1'b0;
    logic          rst, mode, mult_valid, mult_last, stall;
    logic [NW-1:0] n;
    logic [DW-1:0] mult_data, ipsum_data, out_data;
    logic          ipsum_valid, ipsum_ready, acc_in_psum, drain_req, busy;
    logic          out_valid, out_ready, ovf;
    logic [AW:0]   occupancy;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    psum_store_engine #(
        .DATA_WIDTH (DW),
        .PSUM_DEPTH (4),
        .ADDR_WIDTH (AW),
        .N_WIDTH    (NW),
        .FIFO_DEPTH (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mode        (mode),
        .n           (n),
        .mult_valid  (mult_valid),
        .mult_data   (mult_data),
        .mult_last   (mult_last),
        .stall       (stall),
        .ipsum_valid (ipsum_valid),
        .ipsum_data  (ipsum_data),
        .ipsum_ready (ipsum_ready),
        .acc_in_psum (acc_in_psum),
        .drain_req   (drain_req),
        .busy        (busy),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .ovf         (ovf),
        .occupancy   (occupancy)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input int d, input logic last);
        mult_valid = 1'b1;
        mult_data  = DW'(d);
        mult_last  = last;
        tick();
        mult_valid = 1'b0;
        mult_last  = 1'b0;
    endtask

    task automatic drain(input logic acc);
        acc_in_psum = acc;
        drain_req   = 1'b1;
        tick();
        drain_req   = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input int exp);
        int cyc = 0;
        while (!out_valid && cyc < 40) begin
            tick();
            cyc++;
        end
        chk({tag, "_data"}, $signed(out_data), exp);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int cyc = 0;
        while (busy && cyc < 40) begin
            tick();
            cyc++;
        end
        chk({tag, "_idle"}, int'(busy), 0);
    endtask

    task automatic push_ipsum(input int d);
        ipsum_valid = 1'b1;
        ipsum_data  = DW'(d);
        tick();
        ipsum_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; mode = 1'b0; n = '0; mult_valid = 1'b0; mult_data = '0; mult_last = 1'b0;
        ipsum_valid = 1'b0; ipsum_data = '0; acc_in_psum = 1'b0; drain_req = 1'b0; out_ready = 1'b0;
        repeat (3) tick();
        chk("rst_stall", int'(stall), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ipsum_ready", int'(ipsum_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_occ", int'(occupancy), 0);
        rst = 1'b0;
        tick();

        // Mode 0 windows
        beat(3, 1'b0); beat(4, 1'b0);
        chk("m0_occ_open", int'(occupancy), 0);
        beat(5, 1'b1);
        chk("m0_occ1", int'(occupancy), 1);
        beat(7, 1'b1);
        chk("m0_occ2", int'(occupancy), 2);
        drain(1'b0);
        chk("m0_busy", int'(busy), 1);
        pop_expect("m0_out0", 12);
        pop_expect("m0_out1", 7);
        wait_idle("m0");
        chk("m0_occ0", int'(occupancy), 0);

        // Mode 1 interleave, n=3
        mode = 1'b1; n = 4'd3;
        beat(1, 1'b0); beat(2, 1'b0); beat(3, 1'b0);
        beat(10, 1'b0); beat(20, 1'b0); beat(30, 1'b1);
        chk("m1_occ", int'(occupancy), 3);
        drain(1'b0);
        pop_expect("m1_out0", 11);
        pop_expect("m1_out1", 22);
        pop_expect("m1_out2", 33);
        wait_idle("m1");
        mode = 1'b0;

        // Drain with upstream psums, first one late
        beat(12, 1'b1); beat(7, 1'b1);
        drain(1'b1);
        acc_in_psum = 1'b0;
        repeat (4) tick();
        chk("ip_wait_valid", int'(out_valid), 0);
        chk("ip_wait_busy", int'(busy), 1);
        push_ipsum(100);
        push_ipsum(200);
        pop_expect("ip_out0", 112);
        pop_expect("ip_out1", 207);
        wait_idle("ip");

        // Drain request while a window is open
        beat(1, 1'b0); beat(2, 1'b0);
        drain(1'b0);
        chk("pend_busy", int'(busy), 0);
        chk("pend_stall_open", int'(stall), 0);
        beat(3, 1'b1);
        chk("pend_drain_busy", int'(busy), 1);
        chk("pend_stall", int'(stall), 1);
        pop_expect("pend_out", 6);
        wait_idle("pend");
        chk("pend_occ0", int'(occupancy), 0);

        // Scratchpad full
        for (int i = 1; i <= 4; i++) beat(i, 1'b1);
        chk("full_occ", int'(occupancy), 4);
        mult_valid = 1'b1; mult_data = DW'(9); mult_last = 1'b1;
        #1;
        chk("full_stall", int'(stall), 1);
        tick();
        mult_valid = 1'b0; mult_last = 1'b0;
        chk("full_occ_hold", int'(occupancy), 4);
        drain(1'b0);
        for (int i = 1; i <= 4; i++) pop_expect("full_out", i);
        wait_idle("full");
        chk("full_stall_clr", int'(stall), 0);

        // Overflow
        chk("ovf_pre", int'(ovf), 0);
        beat(32767, 1'b0); beat(1, 1'b1);
        chk("ovf_set", int'(ovf), 1);
        drain(1'b0);
`ifdef PSUM_SATURATE_EN
        pop_expect("ovf_out", 32767);
`else
        pop_expect("ovf_out", -32768);
`endif
        wait_idle("ovf");
        chk("ovf_sticky", int'(ovf), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
